// File: rtl/rs_fwd_select_gen_pkg.sv
// Shared types and constants for the RS operand forwarding-select generator.
// Select codes are 4-bit FU indices; all-ones means "no forwarding source".
package rs_fwd_select_gen_pkg;

    localparam int FU_IDX_W = 4;
    localparam logic [FU_IDX_W-1:0] FWD_NONE = 4'hf;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FWD   = 3'd2,
        S_FWDR  = 3'd3,
        S_RFRD  = 3'd4,
        S_READY = 3'd5
    } rs_fwd_state_t;

endpackage

// File: rtl/rs_tag_match_enc.sv
// Compares one tag against all FU writeback broadcasts and returns the
// lowest-index hit. multi flags more than one simultaneous hit.
module rs_tag_match_enc
    import rs_fwd_select_gen_pkg::*;
#(
    parameter int TAG_W = 9,
    parameter int N_FU  = 10
) (
    input  logic [TAG_W-1:0]      tag,
    input  logic [N_FU-1:0]       wb_vld,
    input  logic [N_FU*TAG_W-1:0] wb_tag,
    output logic                  hit,
    output logic [FU_IDX_W-1:0]   idx,
    output logic                  multi
);

    logic [FU_IDX_W-1:0] hit_cnt;

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit     = 1'b0;
        idx     = FWD_NONE;
        hit_cnt = '0;
        for (int k = N_FU - 1; k >= 0; k--) begin
            if (wb_vld[k] && (wb_tag[k*TAG_W +: TAG_W] == tag)) begin
                hit     = 1'b1;
                idx     = FU_IDX_W'(k);
                hit_cnt = hit_cnt + 1'b1;
            end
        end
        multi = (hit_cnt > 4'd1);
    end

endmodule

// File: rtl/rs_fwd_select_gen.sv
// Per-slot operand capture control: watches FU writeback tags and emits the
// live/registered FU select codes, falling back to a regfile re-read.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | slot free
// WAIT    | operand pending, comparing stored tag against broadcasts
// FWD     | capture from live FU bus k this cycle (fuFwd=k)
// FWDR    | capture stalled, take registered FU bus k (fuuFwd=k)
// RFRD    | forwarding window lost, regfile re-read outstanding
// READY   | operand value held in capture register
module rs_fwd_select_gen
    import rs_fwd_select_gen_pkg::*;
#(
    parameter int TAG_W = 9,
    parameter int N_FU  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  alloc,
    input  logic [TAG_W-1:0]      alloc_tag,
    input  logic                  alloc_rdy,
    input  logic                  dealloc,
    input  logic                  rf_ack,
    input  logic [N_FU-1:0]       wb_vld,
    input  logic [N_FU*TAG_W-1:0] wb_tag,
    output logic [3:0]            fuFwd,
    output logic [3:0]            fuuFwd,
    output logic                  ready,
    output logic                  busy,
    output logic                  rf_req,
    output logic [TAG_W-1:0]      rf_tag,
    output logic                  miss
);

    rs_fwd_state_t       state_q, state_d;
    logic [FU_IDX_W-1:0] fu_q, fu_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                miss_q, miss_d;

    logic                alloc_hit, alloc_multi;
    logic [FU_IDX_W-1:0] alloc_idx;
    logic                wait_hit, wait_multi;
    logic [FU_IDX_W-1:0] wait_idx;

    // Allocation bypass: the new tag may be broadcast in the alloc cycle itself.
    rs_tag_match_enc #(
        .TAG_W (TAG_W),
        .N_FU  (N_FU)
    ) u_match_alloc (
        .tag    (alloc_tag),
        .wb_vld (wb_vld),
        .wb_tag (wb_tag),
        .hit    (alloc_hit),
        .idx    (alloc_idx),
        .multi  (alloc_multi)
    );

    rs_tag_match_enc #(
        .TAG_W (TAG_W),
        .N_FU  (N_FU)
    ) u_match_wait (
        .tag    (tag_q),
        .wb_vld (wb_vld),
        .wb_tag (wb_tag),
        .hit    (wait_hit),
        .idx    (wait_idx),
        .multi  (wait_multi)
    );

    always_comb begin
        state_d = state_q;
        fu_d    = fu_q;
        tag_d   = tag_q;
        miss_d  = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else if (alloc) begin
            tag_d = alloc_tag;
            if (alloc_rdy) begin
                state_d = S_READY;
            end else if (alloc_hit) begin
                state_d = S_FWD;
                fu_d    = alloc_idx;
            end else begin
                state_d = S_WAIT;
            end
        end else if (dealloc) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (wait_hit) begin
                        state_d = S_FWD;
                        fu_d    = wait_idx;
                    end
                end
                S_FWD: begin
                    state_d = stall ? S_FWDR : S_READY;
                end
                S_FWDR: begin
                    if (stall) begin
                        state_d = S_RFRD;
                        miss_d  = 1'b1;
                    end else begin
                        state_d = S_READY;
                    end
                end
                // Stall does not matter here: the regfile path writes the
                // capture register on its own once the read returns.
                S_RFRD: begin
                    if (rf_ack) begin
                        state_d = S_READY;
                    end
                end
                S_IDLE, S_READY: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fu_q    <= FWD_NONE;
            tag_q   <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fu_q    <= fu_d;
            tag_q   <= tag_d;
            miss_q  <= miss_d;
        end
    end

    // A tag is produced by exactly one FU; two matching broadcasts is a bug upstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!flush && alloc && !alloc_rdy) begin
                assert (!alloc_multi);
            end
            if (!flush && !alloc && !dealloc && (state_q == S_WAIT)) begin
                assert (!wait_multi);
            end
        end
    end

    assign fuFwd  = (state_q == S_FWD)  ? fu_q : FWD_NONE;
    assign fuuFwd = (state_q == S_FWDR) ? fu_q : FWD_NONE;
    assign ready  = (state_q == S_READY);
    assign busy   = (state_q != S_IDLE);
    assign rf_req = (state_q == S_RFRD);
    assign rf_tag = tag_q;
    assign miss   = miss_q;

endmodule

// File: tb/tb_rs_fwd_select_gen.sv
// Scripted scoreboard bench for rs_fwd_select_gen: each driven cycle pushes
// the expected post-edge outputs, a negedge monitor pops and compares them.
module tb_rs_fwd_select_gen;

    localparam int TAG_W = 9;
    localparam int N_FU  = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall, flush, alloc, alloc_rdy, dealloc, rf_ack;
    logic [TAG_W-1:0]      alloc_tag;
    logic [N_FU-1:0]       wb_vld;
    logic [N_FU*TAG_W-1:0] wb_tag;
    logic [3:0]            fuFwd, fuuFwd;
    logic                  ready, busy, rf_req, miss;
    logic [TAG_W-1:0]      rf_tag;

    typedef struct {
        logic [3:0]       fu;
        logic [3:0]       fuu;
        logic             rdy;
        logic             bsy;
        logic             rfq;
        logic             mis;
        logic [TAG_W-1:0] rft;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rs_fwd_select_gen #(
        .TAG_W (TAG_W),
        .N_FU  (N_FU)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .alloc     (alloc),
        .alloc_tag (alloc_tag),
        .alloc_rdy (alloc_rdy),
        .dealloc   (dealloc),
        .rf_ack    (rf_ack),
        .wb_vld    (wb_vld),
        .wb_tag    (wb_tag),
        .fuFwd     (fuFwd),
        .fuuFwd    (fuuFwd),
        .ready     (ready),
        .busy      (busy),
        .rf_req    (rf_req),
        .rf_tag    (rf_tag),
        .miss      (miss)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("fuFwd",  32'(fuFwd),  32'(e.fu));
            chk("fuuFwd", 32'(fuuFwd), 32'(e.fuu));
            chk("ready",  32'(ready),  32'(e.rdy));
            chk("busy",   32'(busy),   32'(e.bsy));
            chk("rf_req", 32'(rf_req), 32'(e.rfq));
            chk("miss",   32'(miss),   32'(e.mis));
            if (e.rfq) chk("rf_tag", 32'(rf_tag), 32'(e.rft));
        end
    end

    task automatic clear_in();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; alloc = 1'b0; alloc_rdy = 1'b0;
        dealloc = 1'b0; rf_ack = 1'b0; alloc_tag = '0; wb_vld = '0; wb_tag = '0;
    endtask

    task automatic set_wb(input int j, input logic [TAG_W-1:0] t);
        wb_vld[j]              = 1'b1;
        wb_tag[j*TAG_W +: TAG_W] = t;
    endtask

    task automatic set_alloc(input logic [TAG_W-1:0] t, input logic rdy);
        alloc     = 1'b1;
        alloc_tag = t;
        alloc_rdy = rdy;
    endtask

    // Apply the current inputs for one edge and queue the outputs expected after it.
    task automatic step(input logic [3:0] fu, input logic [3:0] fuu, input logic rdy,
                        input logic bsy, input logic rfq, input logic mis,
                        input logic [TAG_W-1:0] rft);
        exp_t e;
        @(posedge clk);
        e.fu = fu; e.fuu = fuu; e.rdy = rdy; e.bsy = bsy;
        e.rfq = rfq; e.mis = mis; e.rft = rft;
        sb_q.push_back(e);
        #1;
        clear_in();
    endtask

    localparam logic [3:0] NF = 4'hf;

    initial begin
        clear_in();
        rst = 1'b1;        step(NF, NF, 0, 0, 0, 0, '0);
        rst = 1'b1;        step(NF, NF, 0, 0, 0, 0, '0);

        // Basic forward from FU3
        set_alloc(9'h005, 0);     step(NF, NF, 0, 1, 0, 0, '0);
        set_wb(3, 9'h005);        step(4'd3, NF, 0, 1, 0, 0, '0);
                                  step(NF, NF, 1, 1, 0, 0, '0);
        set_wb(4, 9'h005);        step(NF, NF, 1, 1, 0, 0, '0);
        dealloc = 1;              step(NF, NF, 0, 0, 0, 0, '0);

        // Non-matching broadcast, then FU9 with one stall cycle
        set_alloc(9'h033, 0);     step(NF, NF, 0, 1, 0, 0, '0);
        set_wb(1, 9'h034);        step(NF, NF, 0, 1, 0, 0, '0);
        set_wb(9, 9'h033);        step(4'd9, NF, 0, 1, 0, 0, '0);
        stall = 1;                step(NF, 4'd9, 0, 1, 0, 0, '0);
                                  step(NF, NF, 1, 1, 0, 0, '0);
        dealloc = 1;              step(NF, NF, 0, 0, 0, 0, '0);

        // FU2 with two stall cycles: window lost, regfile re-read
        set_alloc(9'h144, 0);     step(NF, NF, 0, 1, 0, 0, '0);
        set_wb(2, 9'h144);        step(4'd2, NF, 0, 1, 0, 0, '0);
        stall = 1;                step(NF, 4'd2, 0, 1, 0, 0, '0);
        stall = 1;                step(NF, NF, 0, 1, 1, 1, 9'h144);
        set_wb(5, 9'h144);        step(NF, NF, 0, 1, 1, 0, 9'h144);
        stall = 1;                step(NF, NF, 0, 1, 1, 0, 9'h144);
        rf_ack = 1;               step(NF, NF, 1, 1, 0, 0, '0);
        dealloc = 1;              step(NF, NF, 0, 0, 0, 0, '0);

        // Same-cycle bypass on FU0, then realloc with operand ready
        set_alloc(9'h01A, 0); set_wb(0, 9'h01A);
                                  step(4'd0, NF, 0, 1, 0, 0, '0);
        set_alloc(9'h077, 1);     step(NF, NF, 1, 1, 0, 0, '0);

        // flush beats alloc; alloc from READY goes back to WAIT
        set_alloc(9'h020, 0); set_wb(5, 9'h020);
                                  step(4'd5, NF, 0, 1, 0, 0, '0);
        flush = 1; set_alloc(9'h021, 0);
                                  step(NF, NF, 0, 0, 0, 0, '0);
        set_alloc(9'h021, 1);     step(NF, NF, 1, 1, 0, 0, '0);
        set_alloc(9'h022, 0);     step(NF, NF, 0, 1, 0, 0, '0);

        // Reset mid-WAIT; later matching broadcast must be ignored
        rst = 1;                  step(NF, NF, 0, 0, 0, 0, '0);
        set_wb(4, 9'h022);        step(NF, NF, 0, 0, 0, 0, '0);
                                  step(NF, NF, 0, 0, 0, 0, '0);

        // alloc wins over dealloc; flush from WAIT
        set_alloc(9'h050, 0); dealloc = 1;
                                  step(NF, NF, 0, 1, 0, 0, '0);
        flush = 1; set_wb(6, 9'h050);
                                  step(NF, NF, 0, 0, 0, 0, '0);

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_fwd_select_gen.md
Name: rs_fwd_select_gen

Overview:
- Producer side of the RS operand-capture interface. One instance per RS operand slot.
- Tracks the slot's pending source tag against FU writeback tag broadcasts.
- Generates the 4-bit fuFwd/fuuFwd select codes that the operand-capture datapath uses to latch from FUk (live bus) or FUk_reg (one-cycle-delayed bus).
- Falls back to a register-file read request when a stall outlasts the forwarding window.

Parameters:
TAG_W, 9, physical register tag width
N_FU, 10, number of FU result buses (codes 0..N_FU-1, max 10)

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  capture-side stall; capture register holds when high
flush  in  1  clears slot
alloc  in  1  load new operand into slot
alloc_tag  in  TAG_W  source tag of new operand
alloc_rdy  in  1  operand already in regfile/captured at alloc
dealloc  in  1  slot issued/freed
wb_vld  in  N_FU  FU k broadcasts tag this cycle; data on FUk next cycle
wb_tag  in  N_FU*TAG_W  packed tags, FU k at [k*TAG_W +: TAG_W]
fuFwd  out  4  select live FU bus; 4'hf = none
fuuFwd  out  4  select registered FU bus; 4'hf = none
ready  out  1  operand value held by capture register
busy  out  1  slot allocated
rf_req  out  1  request regfile re-read of tag
rf_tag  out  TAG_W  tag for rf_req
miss  out  1  one-cycle pulse: forwarding window lost

Behaviour:
- Reset: rst synchronous, active-high; clock clk. On reset: state IDLE, fuFwd=fuuFwd=4'hf, ready=0, busy=0, rf_req=0, miss=0, stored tag=0.
- States: IDLE, WAIT, FWD, FWDR, RFRD, READY. All outputs are decoded from registered state plus the registered FU code k (4 bits). Outputs have no combinational path from inputs.
- Hit: wb_vld[j] && wb_tag[j]==tag. Multiple hits select the lowest j; a multi-hit is an assertion failure.
- Transition priority: flush > alloc > dealloc > normal.
  - flush: IDLE next cycle, from any state.
  - alloc in any state:
    - alloc_rdy=1: READY.
    - Otherwise, a same-cycle hit on alloc_tag: FWD with k=j.
    - Otherwise: WAIT.
    - The stored tag is always reloaded.
  - dealloc (no alloc): IDLE.
- Normal transitions:
  - IDLE: stays.
  - WAIT: on hit, FWD with k=j; otherwise stays.
  - FWD (fuFwd=k, fuuFwd=f):
    - ~stall: READY.
    - stall: FWDR.
  - FWDR (fuFwd=f, fuuFwd=k):
    - ~stall: READY.
    - stall: RFRD; miss pulses in the cycle RFRD is entered.
  - RFRD (rf_req=1, rf_tag=tag, codes ff): on rf_ack, READY. Stall is ignored here because the regfile path writes oldData externally.
  - READY (ready=1, codes ff): stays until dealloc/alloc/flush.
- busy=1 in all states except IDLE.
- Codes emitted are exactly 0..N_FU-1 or 4'hf. Code 9 is emitted for FU9, never 10..14.
- At most one of fuFwd/fuuFwd is non-f in any cycle.
- Latency: tag hit in cycle T → fuFwd=k in T+1 → ready=1 in T+2 (no stall).
- Hits arriving in FWD/FWDR/RFRD/READY are ignored. A tag is produced once.

Decomposition:
- Shared package:
  - FWD_NONE = 4'hf.
  - State enum rs_fwd_state_t.
  - FU index width constant (4).
- Sub-module rs_tag_match_enc: N_FU parallel comparators plus lowest-index priority encoder. Outputs hit and 4-bit index. Combinational. Reused for alloc-bypass and WAIT compare; instantiate twice or mux the tag.

Test Plan:
- Reset then alloc tag=0x05 rdy=0; cycle later wb_vld[3], wb_tag[3]=0x05 → next cycle fuFwd=3, fuuFwd=f; following cycle ready=1, codes ff.
- Hit on FU9 with stall=1 during FWD, 0 after → fuFwd=9 one cycle, then fuuFwd=9 one cycle, then ready=1. miss stays 0.
- Hit on FU2, stall held 2 cycles → fuFwd=2, fuuFwd=2, then miss=1 pulse with rf_req=1, rf_tag=tag; rf_ack after 3 cycles → ready=1 next cycle, rf_req=0.
- alloc tag=0x1A same cycle as wb_vld[0], tag 0x1A → fuFwd=0 next cycle (bypass). Alloc with alloc_rdy=1 → ready=1 next cycle, codes ff.
- flush and alloc together while in FWD → IDLE, busy=0, codes ff. Alloc during READY with new unmatched tag → WAIT, ready=0.
- Mid-WAIT rst=1 → all outputs at reset values next cycle. Later matching wb tag is ignored (no fuFwd).
